// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The master modport is the environment; the slave modport is the cache.
interface icache_if;
    logic        is_jump;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        if_rdy;
    logic        inst_needed;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_rdy;
    logic        inst_busy;

    modport master (
        output is_jump, if_req, if_addr, inst_data, inst_rdy, inst_busy,
        input  if_inst, if_rdy, inst_needed, inst_addr
    );

    modport slave (
        input  is_jump, if_req, if_addr, inst_data, inst_rdy, inst_busy,
        output if_inst, if_rdy, inst_needed, inst_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache, one 32-bit word per line,
// with a two-state miss handler towards the memory controller.
module icache #(
    parameter int unsigned INDEX_BITS = 7
) (
    input  logic     clk,
    input  logic     rst,
    icache_if.slave  bus
);
    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 30 - INDEX_BITS;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                state;
    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit;
    logic                  fill;
    logic                  unused_bits;

    assign req_index  = bus.if_addr[INDEX_BITS+1:2];
    assign req_tag    = bus.if_addr[31:INDEX_BITS+2];
    // The latched miss address lives in inst_addr itself.
    assign fill_index = bus.inst_addr[INDEX_BITS+1:2];
    assign fill_tag   = bus.inst_addr[31:INDEX_BITS+2];

    assign hit  = valid[req_index] && (tag_mem[req_index] == req_tag);
    assign fill = (state == MISS) && bus.inst_rdy;

    assign unused_bits = &{1'b0, bus.inst_busy, bus.if_addr[1:0], bus.inst_addr[1:0]};

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= bus.inst_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            valid           <= '0;
            bus.if_inst     <= '0;
            bus.if_rdy      <= 1'b0;
            bus.inst_needed <= 1'b0;
            bus.inst_addr   <= '0;
        end else begin
            bus.if_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.if_req && !bus.is_jump && !bus.if_rdy) begin
                        if (hit) begin
                            bus.if_inst <= data_mem[req_index];
                            bus.if_rdy  <= 1'b1;
                        end else begin
                            bus.inst_addr   <= {bus.if_addr[31:2], 2'b00};
                            bus.inst_needed <= 1'b1;
                            state           <= MISS;
                        end
                    end
                end
                MISS: begin
                    // A fill that coincides with a jump still installs the line.
                    if (bus.inst_rdy) begin
                        valid[fill_index] <= 1'b1;
                        if (!bus.is_jump) begin
                            bus.if_inst <= bus.inst_data;
                            bus.if_rdy  <= 1'b1;
                        end
                    end
                    if (bus.inst_rdy || bus.is_jump) begin
                        bus.inst_needed <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a word-addressed cache model predicts every cycle,
// and literal checks pin the scenario outcomes.
module tb_icache;
    localparam int unsigned IB = 7;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    icache_if bus();

    icache #(.INDEX_BITS(IB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: resident words keyed by word address, at most one per index.
    logic [31:0] cmem [logic [31:0]];
    bit          pending  = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_inst   = '0;
    bit          m_rdy    = 1'b0;
    bit          m_needed = 1'b0;

    function automatic int unsigned idx_of(input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << IB) - 32'd1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin : model
        bit          nr;
        logic [31:0] key;
        logic [31:0] victims [$];
        if (!rst) begin
            cmem.delete();
            pending  = 1'b0;
            m_addr   = '0;
            m_inst   = '0;
            m_rdy    = 1'b0;
            m_needed = 1'b0;
        end else begin
            nr = 1'b0;
            if (!pending) begin
                if (bus.if_req && !bus.is_jump && !m_rdy) begin
                    key = bus.if_addr & ~32'h3;
                    if (cmem.exists(key)) begin
                        nr     = 1'b1;
                        m_inst = cmem[key];
                    end else begin
                        pending  = 1'b1;
                        m_addr   = key;
                        m_needed = 1'b1;
                    end
                end
            end else begin
                if (bus.inst_rdy) begin
                    victims.delete();
                    foreach (cmem[k]) if (idx_of(k) == idx_of(m_addr)) victims.push_back(k);
                    foreach (victims[i]) cmem.delete(victims[i]);
                    cmem[m_addr] = bus.inst_data;
                    if (!bus.is_jump) begin
                        nr     = 1'b1;
                        m_inst = bus.inst_data;
                    end
                end
                if (bus.inst_rdy || bus.is_jump) begin
                    pending  = 1'b0;
                    m_needed = 1'b0;
                end
            end
            m_rdy = nr;
        end
    end

    always @(posedge clk) begin
        #1;
        check("model if_rdy", 32'(bus.if_rdy), 32'(m_rdy));
        check("model inst_needed", 32'(bus.inst_needed), 32'(m_needed));
        check("model inst_addr", bus.inst_addr, m_addr);
        if (m_rdy) check("model if_inst", bus.if_inst, m_inst);
    end

    task automatic drive(input logic jump, input logic req, input logic [31:0] addr,
                         input logic mrdy, input logic [31:0] mdata);
        @(negedge clk);
        bus.is_jump   = jump;
        bus.if_req    = req;
        bus.if_addr   = addr;
        bus.inst_rdy  = mrdy;
        bus.inst_data = mdata;
        bus.inst_busy = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        bus.is_jump = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0;
        bus.inst_rdy = 1'b0; bus.inst_data = '0; bus.inst_busy = 1'b0;
        settle();
        check("reset inst_addr", bus.inst_addr, 32'h0);
        check("reset if_inst", bus.if_inst, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // cold miss, controller answers five cycles later
        drive(1'b0, 1'b1, 32'h0000_1004, 1'b0, 32'h0);
        settle();
        check("cold needed", 32'(bus.inst_needed), 32'd1);
        check("cold inst_addr", bus.inst_addr, 32'h0000_1004);
        repeat (4) idle();
        settle();
        check("cold held", 32'(bus.inst_needed), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0010_0093);
        settle();
        check("cold if_rdy", 32'(bus.if_rdy), 32'd1);
        check("cold if_inst", bus.if_inst, 32'h0010_0093);
        check("cold released", 32'(bus.inst_needed), 32'd0);

        // hit with byte offset bits set
        idle();
        drive(1'b0, 1'b1, 32'h0000_1006, 1'b0, 32'h0);
        settle();
        check("hit if_rdy", 32'(bus.if_rdy), 32'd1);
        check("hit if_inst", bus.if_inst, 32'h0010_0093);
        check("hit no miss", 32'(bus.inst_needed), 32'd0);

        // held request: one response per two cycles
        repeat (4) drive(1'b0, 1'b1, 32'h0000_1004, 1'b0, 32'h0);
        idle();

        // conflict on the same index
        drive(1'b0, 1'b1, 32'h0000_1204, 1'b0, 32'h0);
        settle();
        check("conflict needed", 32'(bus.inst_needed), 32'd1);
        check("conflict inst_addr", bus.inst_addr, 32'h0000_1204);
        repeat (2) idle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        settle();
        check("conflict if_inst", bus.if_inst, 32'hDEAD_BEEF);
        idle();
        drive(1'b0, 1'b1, 32'h0000_1004, 1'b0, 32'h0);
        settle();
        check("evicted remiss", 32'(bus.inst_needed), 32'd1);
        check("evicted inst_addr", bus.inst_addr, 32'h0000_1004);
        idle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0010_0093);
        idle();

        // jump in IDLE drops the request; stray inst_rdy in IDLE ignored
        drive(1'b1, 1'b1, 32'h0000_1204, 1'b0, 32'h0);
        settle();
        check("idle jump no miss", 32'(bus.inst_needed), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA_5555);
        settle();
        check("idle inst_rdy", 32'(bus.if_rdy), 32'd0);

        // jump abort
        drive(1'b0, 1'b1, 32'h0000_2000, 1'b0, 32'h0);
        idle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        settle();
        check("abort needed", 32'(bus.inst_needed), 32'd0);
        check("abort if_rdy", 32'(bus.if_rdy), 32'd0);
        idle();
        drive(1'b0, 1'b1, 32'h0000_2000, 1'b0, 32'h0);
        settle();
        check("abort remiss", 32'(bus.inst_needed), 32'd1);

        // jump coinciding with completion still fills the line
        idle();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
        settle();
        check("jump+rdy if_rdy", 32'(bus.if_rdy), 32'd0);
        check("jump+rdy needed", 32'(bus.inst_needed), 32'd0);
        idle();
        drive(1'b0, 1'b1, 32'h0000_2000, 1'b0, 32'h0);
        settle();
        check("jump fill hit", 32'(bus.if_rdy), 32'd1);
        check("jump fill data", bus.if_inst, 32'h1234_5678);

        // asynchronous reset mid-miss
        idle();
        drive(1'b0, 1'b1, 32'h0000_3000, 1'b0, 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async needed", 32'(bus.inst_needed), 32'd0);
        check("async inst_addr", bus.inst_addr, 32'h0);
        check("async if_inst", bus.if_inst, 32'h0);
        idle();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0BAD_F00D);
        settle();
        check("stray rdy", 32'(bus.if_rdy), 32'd0);
        drive(1'b0, 1'b1, 32'h0000_2000, 1'b0, 32'h0);
        settle();
        check("post-reset miss", 32'(bus.inst_needed), 32'd1);
        check("post-reset addr", bus.inst_addr, 32'h0000_2000);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 7, log2 of line count; one 32-bit word per line, direct-mapped.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 is_jump  input  1  pipeline flush; aborts any outstanding fetch.
REQ-005 if_req  input  1  fetch request from IF stage.
REQ-006 if_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 if_inst  output  32  returned instruction word.
REQ-008 if_rdy  output  1  one-cycle pulse, if_inst valid for the request.
REQ-009 inst_needed  output  1  read request to memory controller, held until completion.
REQ-010 inst_addr  output  32  word address of request to memory controller, bits [1:0] = 0.
REQ-011 inst_data  input  32  word returned by memory controller.
REQ-012 inst_rdy  input  1  memory controller completion pulse; inst_data valid.
REQ-013 inst_busy  input  1  memory controller busy; informational, no effect on function.

Function
REQ-014 Address split: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
REQ-015 Storage per line: valid bit, tag, 32-bit data; valid bits cleared only by reset.
REQ-016 States: IDLE, MISS; exactly two, registered.
REQ-017 IDLE, if_req=1, is_jump=0, if_rdy=0, line valid and tag match (hit): at that edge if_inst <= line data, if_rdy <= 1; state stays IDLE; hit latency 1 cycle.
REQ-018 IDLE, if_req=1, is_jump=0, if_rdy=0, miss: at that edge latch address, inst_addr <= {if_addr[31:2],2'b00}, inst_needed <= 1, state -> MISS; if_rdy stays 0.
REQ-019 if_req ignored in any cycle where if_rdy=1 (max throughput one response per 2 cycles); IF must change address or drop if_req then.
REQ-020 if_addr/if_req changes while in MISS ignored; latched address governs fill and response.
REQ-021 MISS, inst_rdy=0, is_jump=0: hold inst_needed=1 and inst_addr stable.
REQ-022 MISS, inst_rdy=1, is_jump=0: write line (valid=1, tag, inst_data) at latched index; if_inst <= inst_data; if_rdy <= 1; inst_needed <= 0; state -> IDLE; miss latency = controller latency + 1 cycle.
REQ-023 MISS, is_jump=1, inst_rdy=0: inst_needed <= 0, no fill, if_rdy stays 0, state -> IDLE.
REQ-024 MISS, is_jump=1 and inst_rdy=1 same edge: line is filled (data correct for latched address), if_rdy stays 0, inst_needed <= 0, state -> IDLE.
REQ-025 IDLE, is_jump=1: any if_req that cycle dropped; if_rdy <= 0; no miss issued.
REQ-026 inst_rdy in IDLE ignored; no fill, no response.
REQ-027 if_rdy is 0 in every cycle not covered by REQ-017/REQ-022.
REQ-028 Fill of an index with a different tag replaces the line (no write-back; read-only cache).
REQ-029 Lookup and hit response never issue inst_needed.

Reset
REQ-030 rst=0 asynchronously: state IDLE, all valid bits 0, if_inst=0, if_rdy=0, inst_needed=0, inst_addr=0.
REQ-031 Reset during MISS abandons the fetch; a late inst_rdy after release is ignored per REQ-026.
REQ-032 First edge after rst release behaves as IDLE with empty cache.

Verification
REQ-033 Cold miss: after reset, if_req=1, if_addr=0x0000_1004; controller returns 0x0010_0093 with inst_rdy after 5 cycles -> inst_needed=1, inst_addr=0x0000_1004 held until inst_rdy; next cycle if_rdy=1, if_inst=0x0010_0093, inst_needed=0.
REQ-034 Hit: repeat if_addr=0x0000_1006 two cycles later -> if_rdy=1 one cycle after request, if_inst=0x0010_0093, inst_needed never asserted.
REQ-035 Conflict: INDEX_BITS=7, fill 0x0000_1004 then miss on 0x0000_1204 (same index, data 0xDEAD_BEEF) -> second miss issued; then 0x0000_1004 misses again.
REQ-036 Jump abort: miss on 0x0000_2000, assert is_jump 2 cycles later -> inst_needed=0 next edge, no if_rdy; later request to 0x0000_2000 misses.
REQ-037 Jump with inst_rdy same edge, data 0x1234_5678 -> no if_rdy; subsequent request to same address hits with 0x1234_5678.
REQ-038 rst=0 mid-miss -> outputs 0 immediately without clock; after release, stray inst_rdy=1 produces no if_rdy and prior hit address now misses.
